seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier.sv | 146 ++++++++++++++
 tb/tb_seq_multiplier.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
//
// Purpose:
//   Unsigned shift-and-add multiplier that processes one multiplier bit per
//   clock, LSB first. Operands are taken with a valid/ready handshake in IDLE.
//   The finished product is presented with a valid/ready handshake in DONE.
//
// Configuration macro:
//   SEQ_MULT_EARLY_EXIT_EN - when defined, BUSY also finishes as soon as the
//                            remaining (shifted) multiplier bits are all zero.
//                            Products are identical in both builds; only the
//                            latency changes. When undefined, the latency is
//                            always WIDTH edges and no zero-detect is built.
//
// Parameters:
//   WIDTH      operand width in bits (2..32)
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operands A/B are offered
//   in_ready   block can accept operands (state IDLE)
//   A          multiplicand, unsigned, WIDTH bits
//   B          multiplier, unsigned, WIDTH bits
//   out_valid  P holds a finished product (state DONE)
//   out_ready  consumer accepts P
//   P          product A*B, unsigned, 2*WIDTH bits; holds its last value
//   busy       a multiply is in progress (state BUSY)
// -----------------------------------------------------------------------------
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   P,
    output logic                 busy
);

    // Counter only needs to hold bit indices 0..WIDTH-1.
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;   // multiplicand, pre-shifted by bit index
    logic [WIDTH-1:0]     mplier_q, mplier_d; // remaining multiplier bits
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 last_bit;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        last_bit = (cnt_q == CW'(WIDTH - 1));

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mcand_d  = {{WIDTH{1'b0}}, A};
                    mplier_d = B;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_BUSY;
                end
            end

            S_BUSY: begin
                // The product never exceeds (2^WIDTH-1)^2, so the 2*WIDTH-bit
                // accumulator cannot overflow and no carry-out is kept.
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
`ifdef SEQ_MULT_EARLY_EXIT_EN
                if (last_bit || (mplier_d == '0)) begin
                    state_d = S_DONE;
                    p_d     = acc_d;
                end
`else
                if (last_bit) begin
                    state_d = S_DONE;
                    p_d     = acc_d;
                end
`endif
            end

            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_BUSY);
    assign P         = p_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// -----------------------------------------------------------------------------
// tb_seq_multiplier
//
// Drives three multiplier instances (WIDTH = 8, 2 and 16) from one directed
// sequence with random operands, and compares product, latency and handshake
// behaviour against a plain-arithmetic reference (A*B, latency from B's MSB).
// -----------------------------------------------------------------------------
module tb_seq_multiplier;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // sel 0 -> WIDTH 8, sel 1 -> WIDTH 2, sel 2 -> WIDTH 16
    logic        iv8 = 0, or8 = 0, ir8, ov8, bz8;
    logic [7:0]  a8 = 0, b8 = 0;
    logic [15:0] p8;
    logic        iv2 = 0, or2 = 0, ir2, ov2, bz2;
    logic [1:0]  a2 = 0, b2 = 0;
    logic [3:0]  p2;
    logic        iv16 = 0, or16 = 0, ir16, ov16, bz16;
    logic [15:0] a16 = 0, b16 = 0;
    logic [31:0] p16;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
        .out_valid(ov8), .out_ready(or8), .P(p8), .busy(bz8));

    seq_multiplier #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .A(a2), .B(b2),
        .out_valid(ov2), .out_ready(or2), .P(p2), .busy(bz2));

    seq_multiplier #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .A(a16), .B(b16),
        .out_valid(ov16), .out_ready(or16), .P(p16), .busy(bz16));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int width_of(input int sel);
        return (sel == 0) ? 8 : (sel == 1) ? 2 : 16;
    endfunction

    function automatic logic [63:0] get_p(input int sel);
        case (sel)
            0:       return {48'd0, p8};
            1:       return {60'd0, p2};
            default: return {32'd0, p16};
        endcase
    endfunction

    function automatic logic get_valid(input int sel);
        return (sel == 0) ? ov8 : (sel == 1) ? ov2 : ov16;
    endfunction

    function automatic logic get_ready(input int sel);
        return (sel == 0) ? ir8 : (sel == 1) ? ir2 : ir16;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? bz8 : (sel == 1) ? bz2 : bz16;
    endfunction

    task automatic drive(input int sel, input logic v, input logic [31:0] a, input logic [31:0] b);
        case (sel)
            0:       begin iv8  = v; a8  = a[7:0];  b8  = b[7:0];  end
            1:       begin iv2  = v; a2  = a[1:0];  b2  = b[1:0];  end
            default: begin iv16 = v; a16 = a[15:0]; b16 = b[15:0]; end
        endcase
    endtask

    task automatic set_out_ready(input int sel, input logic r);
        case (sel)
            0:       or8  = r;
            1:       or2  = r;
            default: or16 = r;
        endcase
    endtask

    // Reference latency: WIDTH edges, or with early exit the position of B's
    // highest set bit plus one (minimum one edge).
    function automatic int ref_latency(input int w, input logic [63:0] b);
`ifdef SEQ_MULT_EARLY_EXIT_EN
        int msb = 0;
        for (int i = 0; i < w; i++) if (b[i]) msb = i + 1;
        return (msb == 0) ? 1 : msb;
`else
        return w;
`endif
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full transaction. Called at a negedge with the block in IDLE.
    // hold == 0: out_ready held high throughout; hold > 0: consumer stalls
    // for that many cycles in DONE while in_valid is waved at the block.
    task automatic do_op(input int sel, input logic [31:0] a_in, input logic [31:0] b_in, input int hold);
        int          w = width_of(sel);
        logic [63:0] mask = (64'd1 << w) - 64'd1;
        logic [63:0] a = {32'd0, a_in} & mask;
        logic [63:0] b = {32'd0, b_in} & mask;
        logic [63:0] p_exp = a * b;
        int          lat_exp = ref_latency(w, b);
        int          lat = 0;

        check("in_ready_before", {63'd0, get_ready(sel)}, 64'd1);
        drive(sel, 1'b1, a[31:0], b[31:0]);
        set_out_ready(sel, hold == 0);
        next_cycle();                                   // accepting edge
        drive(sel, 1'b0, $urandom, $urandom);           // must be ignored now
        check("busy_after_accept", {63'd0, get_busy(sel)}, 64'd1);
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            next_cycle();
            if (get_valid(sel)) lat = n;
        end
        check("latency", lat, lat_exp);
        check("product", get_p(sel), p_exp);
        check("busy_in_done", {63'd0, get_busy(sel)}, 64'd0);
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                drive(sel, 1'b1, $urandom, $urandom);
                next_cycle();
                check("hold_valid", {63'd0, get_valid(sel)}, 64'd1);
                check("hold_in_ready", {63'd0, get_ready(sel)}, 64'd0);
                check("hold_product", get_p(sel), p_exp);
            end
            drive(sel, 1'b0, 32'd0, 32'd0);
            set_out_ready(sel, 1'b1);
        end
        next_cycle();                                   // handshake edge
        check("valid_dropped", {63'd0, get_valid(sel)}, 64'd0);
        check("in_ready_back", {63'd0, get_ready(sel)}, 64'd1);
        check("product_held", get_p(sel), p_exp);
        set_out_ready(sel, 1'b0);
        $display("op w=%0d A=%0d B=%0d P=%0d lat=%0d hold=%0d", w, a, b, get_p(sel), lat, hold);
    endtask

    initial begin
        // Reset state of all instances
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            check("rst_in_ready", {63'd0, get_ready(s)}, 64'd1);
            check("rst_out_valid", {63'd0, get_valid(s)}, 64'd0);
            check("rst_busy", {63'd0, get_busy(s)}, 64'd0);
            check("rst_p", get_p(s), 64'd0);
        end

        // Corner products
        do_op(0, 32'd255, 32'd255, 0);
        do_op(0, 32'd13, 32'd11, 5);
        do_op(0, 32'd77, 32'd1, 0);
        do_op(0, 32'd99, 32'd0, 0);
        do_op(0, 32'd5, 32'd128, 1);
        do_op(0, 32'd200, 32'd3, 0);

        // Exhaustive WIDTH=2
        for (int i = 0; i < 16; i++) do_op(1, i / 4, i % 4, i % 3);

        // Random WIDTH=8 traffic
        for (int i = 0; i < 20; i++) do_op(0, $urandom, $urandom, $urandom_range(0, 3));

        // Reset three edges into BUSY discards the partial result
        drive(0, 1'b1, 32'd170, 32'd85);
        next_cycle();
        drive(0, 1'b0, 32'd0, 32'd0);
        next_cycle();
        next_cycle();
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        check("midrst_in_ready", {63'd0, ir8}, 64'd1);
        check("midrst_out_valid", {63'd0, ov8}, 64'd0);
        check("midrst_busy", {63'd0, bz8}, 64'd0);
        check("midrst_p", {48'd0, p8}, 64'd0);
        do_op(0, 32'd7, 32'd6, 0);

        // Reset wins over a simultaneous offer
        rst = 1'b1;
        drive(0, 1'b1, 32'd9, 32'd9);
        next_cycle();
        rst = 1'b0;
        drive(0, 1'b0, 32'd0, 32'd0);
        check("rst_vs_valid_busy", {63'd0, bz8}, 64'd0);
        check("rst_vs_valid_ready", {63'd0, ir8}, 64'd1);
        next_cycle();
        check("rst_vs_valid_idle", {63'd0, bz8}, 64'd0);

        // WIDTH=16
        do_op(2, 32'd65535, 32'd65535, 0);
        for (int i = 0; i < 4; i++) do_op(2, $urandom, $urandom, $urandom_range(0, 2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
